// File: rtl/net_domain_link_buffer_pkg.sv
// Shared constants, domain state encoding and sizing helper for the
// per-domain inter-router link buffer.
package net_domain_link_buffer_pkg;

    // Control message = srcdest + opaque + control payload, treated as opaque here
    localparam int c_vc_net_msg_nbits = 44;
    localparam int c_domain_nbits     = 1;

    typedef enum logic [1:0] {
        DOM_EMPTY   = 2'd0,
        DOM_PARTIAL = 2'd1,
        DOM_FULL    = 2'd2
    } dom_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/net_domain_link_buffer_if.sv
// Link-side bundle: one upstream flit port and the per-domain downstream ports.
interface net_domain_link_buffer_if
    import net_domain_link_buffer_pkg::*;
#(
    parameter int p_msg_cnbits   = c_vc_net_msg_nbits,
    parameter int p_msg_dnbits   = 32,
    parameter int p_num_domains  = 2,
    parameter int p_domain_nbits = c_domain_nbits
) ();

    logic                                  in_val;
    logic                                  in_rdy;
    logic [p_domain_nbits-1:0]             in_domain;
    logic [p_msg_cnbits-1:0]               in_msg_control;
    logic [p_msg_dnbits-1:0]               in_msg_data;
    logic [p_num_domains-1:0]              out_val;
    logic [p_num_domains-1:0]              out_rdy;
    logic [p_num_domains*p_msg_cnbits-1:0] out_msg_control;
    logic [p_num_domains*p_msg_dnbits-1:0] out_msg_data;

    modport master (
        output in_val, in_domain, in_msg_control, in_msg_data, out_rdy,
        input  in_rdy, out_val, out_msg_control, out_msg_data
    );

    modport slave (
        input  in_val, in_domain, in_msg_control, in_msg_data, out_rdy,
        output in_rdy, out_val, out_msg_control, out_msg_data
    );

endinterface

// File: rtl/net_domain_link_buffer_fifo.sv
// Single-domain FIFO: synchronous flush that scrubs storage, zero output when
// empty, occupancy count, and a count-derived EMPTY/PARTIAL/FULL state.
module net_domain_fifo
    import net_domain_link_buffer_pkg::*;
#(
    parameter int p_cnbits = c_vc_net_msg_nbits,
    parameter int p_dnbits = 32,
    parameter int p_depth  = 2,
    localparam int c_ptr_nbits = clog2(p_depth),
    localparam int c_cnt_nbits = c_ptr_nbits + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_val,
    input  logic [p_cnbits-1:0]    enq_control,
    input  logic [p_dnbits-1:0]    enq_data,
    output logic                   full,
    output logic                   deq_val,
    input  logic                   deq_rdy,
    output logic [p_cnbits-1:0]    deq_control,
    output logic [p_dnbits-1:0]    deq_data,
    input  logic                   flush,
    output logic [c_cnt_nbits-1:0] count
);

    localparam logic [c_cnt_nbits-1:0] c_cnt_one  = c_cnt_nbits'(1);
    localparam logic [c_cnt_nbits-1:0] c_cnt_full = c_cnt_nbits'(p_depth);
    localparam logic [c_ptr_nbits-1:0] c_ptr_one  = c_ptr_nbits'(1);

    logic [p_cnbits-1:0]    ctrl_mem_r [p_depth];
    logic [p_dnbits-1:0]    data_mem_r [p_depth];
    logic [c_ptr_nbits-1:0] wr_ptr_r;
    logic [c_ptr_nbits-1:0] rd_ptr_r;
    logic [c_cnt_nbits-1:0] count_r;
    dom_state_e             state_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   enq_fire_s;
    logic                   deq_fire_s;

    // Domain state is a pure function of the occupancy register
    always_comb begin
        state_s = DOM_EMPTY;
        if (count_r == {c_cnt_nbits{1'b0}}) begin
            state_s = DOM_EMPTY;
        end else if (count_r == c_cnt_full) begin
            state_s = DOM_FULL;
        end else begin
            state_s = DOM_PARTIAL;
        end
    end

    // Flags; an unknown state refuses both input and output
    always_comb begin
        full_s  = 1'b1;
        empty_s = 1'b1;
        case (state_s)
            DOM_EMPTY:   begin full_s = 1'b0; empty_s = 1'b1; end
            DOM_PARTIAL: begin full_s = 1'b0; empty_s = 1'b0; end
            DOM_FULL:    begin full_s = 1'b1; empty_s = 1'b0; end
            default:     begin full_s = 1'b1; empty_s = 1'b1; end
        endcase
    end

    assign enq_fire_s = enq_val & ~full_s & ~flush;
    assign deq_fire_s = ~empty_s & deq_rdy;

    // Storage, pointers and count; flush wins over any same-cycle traffic
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {c_ptr_nbits{1'b0}};
            rd_ptr_r <= {c_ptr_nbits{1'b0}};
            count_r  <= {c_cnt_nbits{1'b0}};
            for (int i = 0; i < p_depth; i++) begin
                ctrl_mem_r[i] <= {p_cnbits{1'b0}};
                data_mem_r[i] <= {p_dnbits{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {c_ptr_nbits{1'b0}};
            rd_ptr_r <= {c_ptr_nbits{1'b0}};
            count_r  <= {c_cnt_nbits{1'b0}};
            for (int i = 0; i < p_depth; i++) begin
                ctrl_mem_r[i] <= {p_cnbits{1'b0}};
                data_mem_r[i] <= {p_dnbits{1'b0}};
            end
        end else begin
            if (enq_fire_s) begin
                ctrl_mem_r[wr_ptr_r] <= enq_control;
                data_mem_r[wr_ptr_r] <= enq_data;
                wr_ptr_r             <= wr_ptr_r + c_ptr_one;
            end
            if (deq_fire_s) begin
                rd_ptr_r <= rd_ptr_r + c_ptr_one;
            end
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_r <= count_r + c_cnt_one;
                2'b01:   count_r <= count_r - c_cnt_one;
                default: count_r <= count_r;
            endcase
        end
    end

    assign full        = full_s;
    assign deq_val     = ~empty_s;
    assign deq_control = empty_s ? {p_cnbits{1'b0}} : ctrl_mem_r[rd_ptr_r];
    assign deq_data    = empty_s ? {p_dnbits{1'b0}} : data_mem_r[rd_ptr_r];
    assign count       = count_r;

endmodule

// File: rtl/net_domain_link_buffer.sv
// Steers flits from one inter-router link into isolated per-domain FIFOs and
// drops flits whose domain tag is out of range.
module net_domain_link_buffer
    import net_domain_link_buffer_pkg::*;
#(
    parameter int p_msg_cnbits   = c_vc_net_msg_nbits,
    parameter int p_msg_dnbits   = 32,
    parameter int p_num_domains  = 2,
    parameter int p_domain_nbits = c_domain_nbits,
    parameter int p_depth        = 2,
    localparam int c_cnt_nbits   = clog2(p_depth) + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    net_domain_link_buffer_if.slave              link,
    input  logic [p_num_domains-1:0]             flush,
    output logic [p_num_domains*c_cnt_nbits-1:0] occupancy,
    output logic                                 err_drop
);

    localparam logic [p_domain_nbits:0] c_num_dom_tag = (p_domain_nbits + 1)'(p_num_domains);

    logic                                  tag_valid_s;
    logic [p_num_domains-1:0]              accept_s;
    logic [p_num_domains-1:0]              full_s;
    logic [p_num_domains-1:0]              out_val_s;
    logic [p_num_domains*p_msg_cnbits-1:0] out_control_s;
    logic [p_num_domains*p_msg_dnbits-1:0] out_data_s;
    logic                                  err_drop_r;

    assign tag_valid_s = ({1'b0, link.in_domain} < c_num_dom_tag);

    for (genvar k = 0; k < p_num_domains; k++) begin : g_dom
        localparam logic [p_domain_nbits-1:0] c_tag = p_domain_nbits'(k);

        // Ready per domain ignores out_rdy so no combinational path crosses the block
        assign accept_s[k] = (link.in_domain == c_tag) & ~full_s[k] & ~flush[k];

        net_domain_fifo #(
            .p_cnbits (p_msg_cnbits),
            .p_dnbits (p_msg_dnbits),
            .p_depth  (p_depth)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .enq_val     (link.in_val & accept_s[k]),
            .enq_control (link.in_msg_control),
            .enq_data    (link.in_msg_data),
            .full        (full_s[k]),
            .deq_val     (out_val_s[k]),
            .deq_rdy     (link.out_rdy[k]),
            .deq_control (out_control_s[k*p_msg_cnbits +: p_msg_cnbits]),
            .deq_data    (out_data_s[k*p_msg_dnbits +: p_msg_dnbits]),
            .flush       (flush[k]),
            .count       (occupancy[k*c_cnt_nbits +: c_cnt_nbits])
        );
    end

    // Out-of-range tags are always taken and reported one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_drop_r <= 1'b0;
        end else begin
            err_drop_r <= link.in_val & ~tag_valid_s;
        end
    end

    assign link.in_rdy          = reset & (~tag_valid_s | (|accept_s));
    assign link.out_val         = out_val_s;
    assign link.out_msg_control = out_control_s;
    assign link.out_msg_data    = out_data_s;
    assign err_drop             = err_drop_r;

endmodule
